// File: rtl/spi_regfile_pkg.sv
// Shared types and helpers for the SPI register-file peripheral.
package spi_regfile_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    OVER = 2'd3
  } spi_state_e;

  localparam logic SPI_WRITE = 1'b1;

  // Total frame length: one R/W bit, the address field, then the data field.
  function automatic int frame_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_regfile_peripheral_sync.sv
// Two-flop synchroniser plus a history flop for rise/fall detection of one
// asynchronous input. RESET_VAL sets the level assumed while in reset.
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchronise the pin and keep one cycle of history for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
      prev_q <= RESET_VAL;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level = sync_q;
  assign rise  = sync_q & ~prev_q;
  assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 target exposing NUM_REGS registers of DATA_W bits.
// Optional read-back over CIPO is enabled with the SPI_READBACK_EN macro;
// without it cipo/cipo_oe are tied low and read frames are ignored.
module spi_regfile_peripheral
  import spi_regfile_pkg::*;
#(
  parameter int NUM_REGS = 5,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 7
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sclk,
  input  logic                       cs_n,
  input  logic                       copi,
  output logic                       cipo,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);

  localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0]  CNT_FULL     = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0]  CNT_ADDR_END = CNT_W'(ADDR_W);
  localparam logic [ADDR_W:0]   REG_LIMIT    = (ADDR_W + 1)'(NUM_REGS);

  logic sclk_level, sclk_rise, sclk_fall;
  logic cs_level, cs_rise, cs_fall;
  logic copi_meta, copi_sync;

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sclk_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sclk),
    .level (sclk_level),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  // cs_n is assumed low while in reset so a frame already in progress at
  // reset release is not mistaken for a fresh falling edge.
  spi_sync_edge #(.RESET_VAL(1'b0)) u_cs_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (cs_n),
    .level (cs_level),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  // Plain two-flop synchroniser for copi; aligned with the sclk edge flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      copi_meta <= 1'b0;
      copi_sync <= 1'b0;
    end else begin
      copi_meta <= copi;
      copi_sync <= copi_meta;
    end
  end

  spi_state_e               state, state_next;
  logic [CNT_W-1:0]         bit_cnt;
  logic [FRAME_W-1:0]       shift_in, shift_next;
  logic [DATA_W-1:0]        regs [NUM_REGS];
  logic                     frame_rw;
  logic [ADDR_W-1:0]        frame_addr;
  logic [DATA_W-1:0]        frame_data;
  logic                     frame_clean, addr_ok, do_commit, do_err;

  // Decode the captured frame and decide commit/error at cs_n rise.
  always_comb begin
    shift_next  = {shift_in[FRAME_W-2:0], copi_sync};
    frame_rw    = shift_in[FRAME_W-1];
    frame_addr  = shift_in[FRAME_W-2 -: ADDR_W];
    frame_data  = shift_in[DATA_W-1:0];
    frame_clean = (state == DATA) && (bit_cnt == CNT_FULL);
    addr_ok     = ({1'b0, frame_addr} < REG_LIMIT);
    do_commit   = cs_rise && frame_clean && (frame_rw == SPI_WRITE) && addr_ok;
    do_err      = cs_rise && (state != IDLE) &&
                  (!frame_clean || ((frame_rw == SPI_WRITE) && !addr_ok));
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // FSM next state; a cs_n rise wins over any simultaneous sclk edge.
  always_comb begin
    state_next = state;
    if (cs_rise) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (cs_fall) state_next = CMD;
        CMD:  if (sclk_rise && (bit_cnt == CNT_ADDR_END)) state_next = DATA;
        DATA: if (sclk_rise && (bit_cnt == CNT_FULL)) state_next = OVER;
        OVER: state_next = OVER;
        default: state_next = IDLE;
      endcase
    end
  end

  // Shift in copi and count bits (saturating) while a frame is active.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      shift_in <= '0;
    end else if (cs_rise) begin
      bit_cnt  <= bit_cnt;
    end else if ((state == IDLE) && cs_fall) begin
      bit_cnt  <= '0;
      shift_in <= '0;
    end else if (sclk_rise && (state != IDLE)) begin
      shift_in <= shift_next;
      if (bit_cnt != CNT_FULL) bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

  // Register bank plus the single-cycle write and error pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      wr_addr   <= '0;
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      wr_strobe <= do_commit;
      frame_err <= do_err;
      if (do_commit) begin
        wr_addr <= frame_addr;
        for (int i = 0; i < NUM_REGS; i++)
          if (frame_addr == ADDR_W'(i)) regs[i] <= frame_data;
      end
    end
  end

  // Flatten the bank onto the output bus.
  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < NUM_REGS; i++) regs_flat[i*DATA_W +: DATA_W] = regs[i];
  end

`ifdef SPI_READBACK_EN
  logic              rd_rw;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] shift_out;
  logic              rd_active;
  logic              load_read;
  logic              unused_sync;

  assign unused_sync = ^{sclk_level, cs_level};

  // Select the read word as the final address bit is captured; out-of-range reads zero.
  always_comb begin
    rd_rw     = shift_next[ADDR_W];
    rd_addr   = shift_next[ADDR_W-1:0];
    rd_word   = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (rd_addr == ADDR_W'(i)) rd_word = regs[i];
    load_read = !cs_rise && (state == CMD) && sclk_rise &&
                (bit_cnt == CNT_ADDR_END) && (rd_rw != SPI_WRITE);
  end

  // Drive cipo MSB first on sclk falling edges during the data phase of a read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cipo      <= 1'b0;
      cipo_oe   <= 1'b0;
      shift_out <= '0;
      rd_active <= 1'b0;
    end else if (cs_rise) begin
      cipo      <= 1'b0;
      cipo_oe   <= 1'b0;
      rd_active <= 1'b0;
    end else if ((state == IDLE) && cs_fall) begin
      cipo      <= 1'b0;
      cipo_oe   <= 1'b1;
      rd_active <= 1'b0;
    end else if (load_read) begin
      shift_out <= rd_word;
      rd_active <= 1'b1;
    end else if (state == OVER) begin
      cipo      <= 1'b0;
    end else if (sclk_fall && rd_active && (state == DATA)) begin
      cipo      <= shift_out[DATA_W-1];
      shift_out <= {shift_out[DATA_W-2:0], 1'b0};
    end
  end
`else
  logic unused_sync;

  assign unused_sync = ^{sclk_level, sclk_fall, cs_level};
  assign cipo        = 1'b0;
  assign cipo_oe     = 1'b0;
`endif

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Scoreboard bench for spi_regfile_peripheral: a default-size instance and a
// 16x16-bit instance share sclk/copi but have separate chip selects.
module tb_spi_regfile_peripheral;

`ifdef SPI_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, sclk, copi, cs_n_a, cs_n_b;

  logic         cipo_a, cipo_oe_a, wr_strobe_a, frame_err_a;
  logic [39:0]  regs_a;
  logic [6:0]   wr_addr_a;
  logic         cipo_b, cipo_oe_b, wr_strobe_b, frame_err_b;
  logic [255:0] regs_b;
  logic [3:0]   wr_addr_b;

  typedef struct {
    bit          is_write;
    int          addr;
    logic [15:0] data;
  } sb_event_t;

  sb_event_t exp_a[$];
  sb_event_t exp_b[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_regfile_peripheral dut_a (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n_a), .copi(copi),
    .cipo(cipo_a), .cipo_oe(cipo_oe_a), .regs_flat(regs_a),
    .wr_strobe(wr_strobe_a), .wr_addr(wr_addr_a), .frame_err(frame_err_a)
  );

  spi_regfile_peripheral #(.NUM_REGS(16), .DATA_W(16), .ADDR_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n_b), .copi(copi),
    .cipo(cipo_b), .cipo_oe(cipo_oe_b), .regs_flat(regs_b),
    .wr_strobe(wr_strobe_b), .wr_addr(wr_addr_b), .frame_err(frame_err_b)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One SPI mode-0 frame; optional reset pulse after bit reset_after.
  task automatic applyStimulus(input bit wide, input int nbits, input logic [31:0] frame,
                               input int gap, input int reset_after,
                               output logic [31:0] rx, output logic oe_mid);
    rx = '0;
    if (wide) cs_n_b = 1'b0; else cs_n_a = 1'b0;
    #100;
    oe_mid = wide ? cipo_oe_b : cipo_oe_a;
    for (int i = nbits - 1; i >= 0; i--) begin
      copi = frame[i];
      #80;
      sclk = 1'b1;
      rx = {rx[30:0], (wide ? cipo_b : cipo_a)};
      #80;
      sclk = 1'b0;
      if ((nbits - i) == reset_after) begin
        rst_n = 1'b0;
        #20;
        rst_n = 1'b1;
      end
    end
    #80;
    if (wide) cs_n_b = 1'b1; else cs_n_a = 1'b1;
    #(gap);
  endtask

  // Monitor for the default instance: each pulse pops the oldest expectation.
  always @(negedge clk) begin
    if (wr_strobe_a || frame_err_a) begin
      if (exp_a.size() == 0) begin
        checkOutput("unexpected_pulse_a", 64'({wr_strobe_a, frame_err_a}), 64'd0);
      end else begin
        sb_event_t ev;
        ev = exp_a.pop_front();
        checkOutput("wr_strobe_a", 64'(wr_strobe_a), 64'(ev.is_write));
        checkOutput("frame_err_a", 64'(frame_err_a), 64'(!ev.is_write));
        if (ev.is_write) begin
          checkOutput("wr_addr_a", 64'(wr_addr_a), 64'(ev.addr));
          checkOutput("wr_data_a", 64'(regs_a[ev.addr*8 +: 8]), 64'(ev.data[7:0]));
        end
      end
    end
  end

  // Monitor for the wide instance.
  always @(negedge clk) begin
    if (wr_strobe_b || frame_err_b) begin
      if (exp_b.size() == 0) begin
        checkOutput("unexpected_pulse_b", 64'({wr_strobe_b, frame_err_b}), 64'd0);
      end else begin
        sb_event_t ev;
        ev = exp_b.pop_front();
        checkOutput("wr_strobe_b", 64'(wr_strobe_b), 64'(ev.is_write));
        checkOutput("frame_err_b", 64'(frame_err_b), 64'(!ev.is_write));
        if (ev.is_write) begin
          checkOutput("wr_addr_b", 64'(wr_addr_b), 64'(ev.addr));
          checkOutput("wr_data_b", 64'(regs_b[ev.addr*16 +: 16]), 64'(ev.data));
        end
      end
    end
  end

  initial begin
    logic [31:0] rx;
    logic        oe;

    rst_n = 1'b0; sclk = 1'b0; copi = 1'b0; cs_n_a = 1'b1; cs_n_b = 1'b1;
    #90;
    checkOutput("reset_regs_a", 64'(regs_a), 64'd0);
    checkOutput("reset_cipo_a", 64'(cipo_a), 64'd0);
    checkOutput("reset_oe_a", 64'(cipo_oe_a), 64'd0);
    checkOutput("reset_strobe_a", 64'(wr_strobe_a), 64'd0);
    checkOutput("reset_wr_addr_a", 64'(wr_addr_a), 64'd0);
    checkOutput("reset_err_a", 64'(frame_err_a), 64'd0);
    checkOutput("reset_regs_b", 64'(regs_b), 64'd0);
    #10;
    rst_n = 1'b1;
    #100;

    $display("[TB] write 0xA5 to address 2");
    exp_a.push_back('{is_write: 1'b1, addr: 2, data: 16'h00A5});
    applyStimulus(1'b0, 16, 32'h82A5, 200, 0, rx, oe);
    checkOutput("regs_after_write", 64'(regs_a), 64'h00_0000_A5_0000);
    checkOutput("oe_during_write", 64'(oe), 64'(RB));
    checkOutput("oe_after_write", 64'(cipo_oe_a), 64'd0);

    $display("[TB] read back address 2");
    applyStimulus(1'b0, 16, 32'h0200, 200, 0, rx, oe);
    checkOutput("read_addr2_data", 64'(rx[7:0]), 64'(RB ? 8'hA5 : 8'h00));
    checkOutput("oe_during_read", 64'(oe), 64'(RB));
    checkOutput("oe_after_read", 64'(cipo_oe_a), 64'd0);
    checkOutput("cipo_after_read", 64'(cipo_a), 64'd0);

    $display("[TB] short and long frames");
    exp_a.push_back('{is_write: 1'b0, addr: 0, data: 16'h0000});
    applyStimulus(1'b0, 15, 32'h40FF, 200, 0, rx, oe);
    exp_a.push_back('{is_write: 1'b0, addr: 0, data: 16'h0000});
    applyStimulus(1'b0, 17, 32'h103FF, 200, 0, rx, oe);
    checkOutput("regs_after_bad_len", 64'(regs_a), 64'h00_0000_A5_0000);

    $display("[TB] out-of-range write and read");
    exp_a.push_back('{is_write: 1'b0, addr: 0, data: 16'h0000});
    applyStimulus(1'b0, 16, 32'h873C, 200, 0, rx, oe);
    checkOutput("regs_after_oor_write", 64'(regs_a), 64'h00_0000_A5_0000);
    applyStimulus(1'b0, 16, 32'h0700, 200, 0, rx, oe);
    checkOutput("read_addr7_data", 64'(rx[7:0]), 64'd0);
    checkOutput("cipo_after_oor_read", 64'(cipo_a), 64'd0);

    $display("[TB] reset in the middle of a write frame");
    applyStimulus(1'b0, 16, 32'h8377, 200, 9, rx, oe);
    checkOutput("regs_after_mid_reset", 64'(regs_a), 64'd0);
    exp_a.push_back('{is_write: 1'b1, addr: 4, data: 16'h0011});
    applyStimulus(1'b0, 16, 32'h8411, 200, 0, rx, oe);
    checkOutput("regs_after_addr4_write", 64'(regs_a), 64'h11_0000_0000);

    $display("[TB] wide instance, back-to-back writes");
    exp_b.push_back('{is_write: 1'b1, addr: 3, data: 16'hBEEF});
    applyStimulus(1'b1, 21, 32'h13BEEF, 40, 0, rx, oe);
    exp_b.push_back('{is_write: 1'b1, addr: 15, data: 16'h1234});
    applyStimulus(1'b1, 21, 32'h1F1234, 200, 0, rx, oe);
    checkOutput("wide_reg3", 64'(regs_b[63:48]), 64'hBEEF);
    checkOutput("wide_reg15", 64'(regs_b[255:240]), 64'h1234);
    applyStimulus(1'b1, 21, 32'h030000, 200, 0, rx, oe);
    checkOutput("wide_read_reg3", 64'(rx[15:0]), 64'(RB ? 16'hBEEF : 16'h0000));
    checkOutput("wide_cipo_idle", 64'(cipo_b), 64'd0);

    #200;
    checkOutput("pending_events_a", 64'(exp_a.size()), 64'd0);
    checkOutput("pending_events_b", 64'(exp_b.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_regfile_peripheral.md
# spi_regfile_peripheral

Parametrised SPI mode-0 target that exposes a bank of `NUM_REGS` configuration registers, each `DATA_W` bits wide, to an external SPI controller. It supports both writes and read-back over CIPO. It sits between the chip's SPI pins and the PWM/output-enable logic, and replaces the fixed 5 × 8-bit write-only register interface. All SPI inputs are asynchronous to `clk` and are synchronised internally.

## Interface
- `NUM_REGS`, 5, number of registers; legal range 1..2^ADDR_W.
- `DATA_W`, 8, register and data-field width in bits.
- `ADDR_W`, 7, address-field width in bits.
- `clk` input 1: system clock, which must be at least 8× the `sclk` frequency.
- `rst_n` input 1: synchronous, active-low reset.
- `sclk` input 1: SPI clock, asynchronous, idles low.
- `cs_n` input 1: SPI chip select, asynchronous, active low.
- `copi` input 1: controller-out data, asynchronous.
- `cipo` output 1: peripheral-out data.
- `cipo_oe` output 1: pad output-enable for `cipo`.
- `regs_flat` output NUM_REGS*DATA_W: register bank; register i occupies bits [i*DATA_W +: DATA_W].
- `wr_strobe` output 1: one-cycle pulse when a write commits.
- `wr_addr` output ADDR_W: address of the last committed write.
- `frame_err` output 1: one-cycle pulse when a frame is rejected.

## Operation
- Frame format, MSB first: FRAME_W = 1 + ADDR_W + DATA_W bits.
  - Bit [FRAME_W-1] is R/W: 1 = write, 0 = read.
  - Next ADDR_W bits are the address.
  - Final DATA_W bits are the data.
- Synchronisers: `sclk`, `cs_n` and `copi` each pass through 2 flops.
  - A third flop on `sclk` and on `cs_n` provides rise/fall edge detection.
- `copi` is sampled on each synchronised `sclk` rising edge while `cs_n` is low.
- `cipo` updates on each synchronised `sclk` falling edge.
- FSM states:
  - IDLE → CMD on synchronised `cs_n` falling edge; clears the bit counter and shift register.
  - CMD → DATA once the rising edge that captures the final address bit occurs.
  - DATA → OVER if a rising edge arrives with bit count already at FRAME_W.
  - Any state → IDLE on synchronised `cs_n` rising edge; this is where the commit decision is made.
- Bit counter is $clog2(FRAME_W+1) bits wide and saturates at FRAME_W.
- Write commit, on `cs_n` rise, requires all of:
  - state is DATA,
  - count == FRAME_W,
  - R/W = 1,
  - address < NUM_REGS.
  - On commit: load the register, set `wr_addr`, pulse `wr_strobe`.
- Read: in DATA with R/W = 0, the addressed register is loaded into the output shift register.
  - An out-of-range address reads all zeros.
  - `cipo` shifts the register out MSB first; the data field received on `copi` during a read is ignored.
- `frame_err` pulses on `cs_n` rise when the state is CMD/DATA/OVER and the frame is not a clean FRAME_W-bit frame, or when a write address is ≥ NUM_REGS.
  - A `cs_n` rise from IDLE is not an error.
- Priority: a `cs_n` rise in the same cycle as an `sclk` edge is processed as the `cs_n` rise; that `sclk` edge is ignored.
- Reset values: all registers 0, `cipo` 0, `cipo_oe` 0, `wr_strobe` 0, `wr_addr` 0, `frame_err` 0, state IDLE.
- Reset asserted mid-frame discards the frame. SPI activity during reset is ignored. The first frame after reset requires a fresh `cs_n` falling edge.

## Timing
- Latency from pin edge to acting on it: 3 `clk` cycles (2 sync flops + 1 edge-detect flop).
- Write commit: `regs_flat`, `wr_addr` and `wr_strobe` update 1 cycle after the synchronised `cs_n` rise is detected, i.e. 4 `clk` cycles after the `cs_n` pin rises.
- Read data timing:
  - The first data MSB drives `cipo` at the falling edge that follows the last address bit's rising edge.
  - It updates within 4 `clk` cycles of the `sclk` pin falling, so it is valid before the next rising edge at clk ≥ 8× sclk.
- `cipo_oe` is 1 from the synchronised `cs_n` fall to the synchronised `cs_n` rise.
- `cipo` is 0 outside the data phase of a read.
- Back-to-back frames: a `cs_n` high time of at least 4 `clk` cycles is required.

## Configuration
- `SPI_READBACK_EN` defined: read frames drive `cipo` as described above.
- `SPI_READBACK_EN` undefined:
  - `cipo` and `cipo_oe` are tied to 0 and the read shift logic is removed.
  - Read frames are silently ignored: no register change, no `frame_err`.

## Structure
- Package `spi_regfile_pkg` contains:
  - the FSM state typedef (IDLE, CMD, DATA, OVER),
  - constant `SPI_WRITE = 1'b1`,
  - function `frame_w(addr_w, data_w)`.
- Sub-module `spi_sync_edge`: 2-flop synchroniser plus edge detector, outputs `level`, `rise`, `fall`.
  - One instance each for `sclk` and `cs_n`; `copi` uses the synchroniser path only.

## Test plan
- Defaults, write frame 1_0000010_10100101 → `regs_flat[23:16]` = 0xA5, `wr_strobe` high for exactly 1 cycle, `wr_addr` = 2, other registers remain 0.
- After that write, read frame 0_0000010_xxxxxxxx → `cipo` shows 1,0,1,0,0,1,0,1 at the 8 data rising edges, `cipo_oe` high only while `cs_n` is low.
- 15-bit write frame to address 1, then a 17-bit write frame → no register change, `frame_err` pulses once per frame, no `wr_strobe`.
- Write 0x3C to address 7 (≥ NUM_REGS) → no change, `frame_err` pulse; read of address 7 returns 0x00 on `cipo`.
- `rst_n` low for 2 cycles after bit 9 of a write frame, then the frame completes → no write; a following valid write of 0x11 to address 4 sets `regs_flat[39:32]` = 0x11.
- Two write frames separated by exactly 4 `clk` cycles of `cs_n` high, with NUM_REGS=16, DATA_W=16, ADDR_W=4 → both commit.
  - Repeat with `SPI_READBACK_EN` undefined and a read frame → `cipo` stays 0 and `frame_err` stays 0.
